// File: rtl/mux_input_ctrl.sv
// Purpose: synchronize/debounce two buttons; toggle sel on one, latch operand switches on the other.
// Latency: a clean press updates sel/a/b and its strobe DB_CYCLES+2 edges after the raw rise.
// Backpressure: none; free-running front end, every debounced press is applied on its edge.
module mux_input_ctrl #(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn_sel,
    input  logic       btn_load,
    output logic [1:0] a,
    output logic [1:0] b,
    output logic       sel,
    output logic       sel_pulse,
    output logic       load_pulse
);

    // Terminal count: db follows s on the DB_CYCLES-th consecutive differing sample.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // Two-flop synchronizers; button index 0 is select, index 1 is load.
    logic [3:0] sw_m_q, sw_s_q;
    logic [1:0] btn_m_q, btn_s_q;

    // Debouncer state per button.
    logic [1:0]            db_q, db_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]            press;

    // Output registers.
    logic [1:0] a_q, a_d, b_q, b_d;
    logic       sel_q, sel_d;
    logic       sel_pulse_q, sel_pulse_d;
    logic       load_pulse_q, load_pulse_d;

    // Debounce: any sample agreeing with db restarts the count, so short glitches never land.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (btn_s_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                db_d[i]  = btn_s_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        // Only the rising debounced edge is an event; releases are silent.
        press = db_d & ~db_q;
    end

    // Output next-state: select and load events act independently on the same edge.
    always_comb begin
        sel_d        = sel_q ^ press[0];
        sel_pulse_d  = press[0];
        load_pulse_d = press[1];
        a_d          = a_q;
        b_d          = b_q;
        if (press[1]) begin
            a_d = sw_s_q[1:0];
            b_d = sw_s_q[3:2];
        end
    end

    // All state clears asynchronously, so a held button is re-debounced after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_m_q       <= '0;
            sw_s_q       <= '0;
            btn_m_q      <= '0;
            btn_s_q      <= '0;
            db_q         <= '0;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= 1'b0;
            sel_pulse_q  <= 1'b0;
            load_pulse_q <= 1'b0;
        end else begin
            sw_m_q       <= sw;
            sw_s_q       <= sw_m_q;
            btn_m_q      <= {btn_load, btn_sel};
            btn_s_q      <= btn_m_q;
            db_q         <= db_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sel_q        <= sel_d;
            sel_pulse_q  <= sel_pulse_d;
            load_pulse_q <= load_pulse_d;
        end
    end

    assign a          = a_q;
    assign b          = b_q;
    assign sel        = sel_q;
    assign sel_pulse  = sel_pulse_q;
    assign load_pulse = load_pulse_q;

endmodule

// File: tb/tb_mux_input_ctrl.sv
// Purpose: bench for mux_input_ctrl with a window-based debounce model and directed literal pins.
// Latency: model predicts outputs after each edge; compared every falling edge.
// Backpressure: not applicable.
module tb_mux_input_ctrl;

    localparam int DB  = 4;
    localparam int LEN = DB + 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] sw = 4'h0;
    logic       btn_sel = 1'b0;
    logic       btn_load = 1'b0;
    logic [1:0] a, b;
    logic       sel, sel_pulse, load_pulse;

    int checks = 0;
    int errors = 0;

    mux_input_ctrl #(.DB_CYCLES(DB), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .sw(sw), .btn_sel(btn_sel), .btn_load(btn_load),
        .a(a), .b(b), .sel(sel), .sel_pulse(sel_pulse), .load_pulse(load_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: raw samples kept per edge; the synchronized value seen at an
    // edge is the raw value two edges earlier; a debounced level flips once the last
    // DB synchronized samples all disagree with it.
    logic [5:0] hist[$];
    bit         m_db_sel, m_db_load, m_sel, m_sp, m_lp, m_fs, m_fl;
    logic [1:0] m_a, m_b;
    int         ev_sel = 0, ev_load = 0;

    function automatic void m_reset();
        hist.delete();
        for (int i = 0; i < LEN; i++) hist.push_back(6'd0);
        m_db_sel = 0; m_db_load = 0; m_sel = 0; m_sp = 0; m_lp = 0;
        m_a = 2'd0; m_b = 2'd0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_reset();
        end else begin
            hist.push_back({btn_load, btn_sel, sw});
            void'(hist.pop_front());
            m_fs = 1; m_fl = 1;
            for (int i = 0; i < DB; i++) begin
                if (hist[LEN-3-i][4] == m_db_sel)  m_fs = 0;
                if (hist[LEN-3-i][5] == m_db_load) m_fl = 0;
            end
            m_sp = m_fs && !m_db_sel;
            m_lp = m_fl && !m_db_load;
            if (m_fs) m_db_sel  = !m_db_sel;
            if (m_fl) m_db_load = !m_db_load;
            if (m_sp) begin m_sel = !m_sel; ev_sel++; end
            if (m_lp) begin m_a = hist[LEN-3][1:0]; m_b = hist[LEN-3][3:2]; ev_load++; end
        end
    end

    // Continuous comparison against the model.
    always @(negedge clk) begin
        chk("model_a", a, m_a);
        chk("model_b", b, m_b);
        chk("model_sel", sel, m_sel);
        chk("model_sel_pulse", sel_pulse, m_sp);
        chk("model_load_pulse", load_pulse, m_lp);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        step(2);
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_sel", sel, 0);
        chk("rst_sp", sel_pulse, 0);
        chk("rst_lp", load_pulse, 0);
        rst = 1'b0;
        step(20);
        chk("idle_sel", sel, 0);
        chk("idle_a", a, 0);

        // Clean select press, held, released, pressed again.
        btn_sel = 1'b1;
        step(5);  chk("press_e5_sel", sel, 0);
        step(1);  chk("press_e6_sel", sel, 1); chk("press_e6_sp", sel_pulse, 1);
        step(1);  chk("press_e7_sp", sel_pulse, 0);
        step(13); btn_sel = 1'b0;
        step(12); chk("release_sel", sel, 1);
        btn_sel = 1'b1;
        step(6);  chk("press2_sel", sel, 0); chk("press2_sp", sel_pulse, 1);
        step(1);  btn_sel = 1'b0;
        step(12);

        // Bounce: 3 high / 1 low, five times, then a steady press.
        for (int k = 0; k < 5; k++) begin
            btn_sel = 1'b1; step(3);
            btn_sel = 1'b0; step(1);
        end
        chk("bounce_sel", sel, 0);
        btn_sel = 1'b1;
        step(5);  chk("bounce_e5_sel", sel, 0);
        step(1);  chk("bounce_e6_sel", sel, 1); chk("bounce_e6_sp", sel_pulse, 1);
        step(10); btn_sel = 1'b0;
        step(12);

        // Load with switches 1001, then switch change without a press.
        sw = 4'b1001; step(3);
        btn_load = 1'b1;
        step(6);  chk("load_a", a, 2'b01); chk("load_b", b, 2'b10); chk("load_lp", load_pulse, 1);
        step(1);  chk("load_lp_off", load_pulse, 0);
        sw = 4'b0110; step(3);
        btn_load = 1'b0; step(12);
        chk("hold_a", a, 2'b01); chk("hold_b", b, 2'b10);

        // Simultaneous presses.
        sw = 4'b1100; step(3);
        btn_sel = 1'b1; btn_load = 1'b1;
        step(6);
        chk("sim_sel", sel, 0); chk("sim_a", a, 2'b00); chk("sim_b", b, 2'b11);
        chk("sim_sp", sel_pulse, 1); chk("sim_lp", load_pulse, 1);
        step(1); btn_sel = 1'b0; btn_load = 1'b0;
        step(12);

        // Reset in the middle of a debounce count with the button held.
        btn_sel = 1'b1;
        step(4); rst = 1'b1;
        chk("rstmid_sel", sel, 0);
        step(2); chk("rstmid_hold_sel", sel, 0);
        rst = 1'b0;
        step(5); chk("rstmid_e5_sel", sel, 0);
        step(1); chk("rstmid_e6_sel", sel, 1); chk("rstmid_e6_sp", sel_pulse, 1);
        btn_sel = 1'b0; step(12);

        // Randomized phase, checked by the model only.
        for (int c = 0; c < 3000; c++) begin
            step(1);
            if ($urandom_range(0, 5) == 0) btn_sel  = ~btn_sel;
            if ($urandom_range(0, 5) == 0) btn_load = ~btn_load;
            if ($urandom_range(0, 3) == 0) sw = 4'($urandom_range(0, 15));
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
        end
        rst = 1'b0;
        step(2);
        chk("events_seen", (ev_sel > 10 && ev_load > 10), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_input_ctrl.md
# mux_input_ctrl

Front-end stage that drives the 2-bit 2:1 selector datapath from board switches and push-buttons. It synchronizes and debounces two buttons. It toggles the select line on each press of one button and latches the operand switches on each press of the other. It outputs registered operands `a`, `b` and select `sel`, ready to feed the selector directly.

## Interface
Parameters:
- `DB_CYCLES`, default 1000000: consecutive stable synchronized cycles required before a debounced level changes (10 ms at 100 MHz); legal range ≥ 2.
- `CNT_W`, default 20: debounce counter width; must satisfy 2^CNT_W > DB_CYCLES-1.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sw`  in  4  raw operand switches; `sw[1:0]` is the source for `a`, `sw[3:2]` for `b`; asynchronous to `clk`.
- `btn_sel`  in  1  raw select button, active-high, bouncy.
- `btn_load`  in  1  raw load button, active-high, bouncy.
- `a`  out  2  registered operand A.
- `b`  out  2  registered operand B.
- `sel`  out  1  registered select (0 selects `a`, 1 selects `b` downstream).
- `sel_pulse`  out  1  one-cycle strobe, high in the cycle `sel` takes its new value.
- `load_pulse`  out  1  one-cycle strobe, high in the cycle `a`/`b` take new values.

## Operation
- **Synchronizers.** `sw`, `btn_sel` and `btn_load` each pass through a 2-flop synchronizer. The debouncers and the latches use only the synchronized values `s_*`.
- **Debouncer.** There is one per button. Each holds a debounced level `db` and a counter `cnt`, updated every edge:
  - If `s == db`: `cnt <= 0`.
  - Else if `cnt == DB_CYCLES-1`: `db <= s`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - Any return of `s` to `db` before the terminal count clears `cnt`, so a glitch shorter than `DB_CYCLES` cycles never changes `db`.
- **Press event.** A press event occurs only on the edge where `db` goes 0→1. A release (1→0) produces no event.
- **Select press.** On that same edge: `sel <= ~sel` and `sel_pulse <= 1`. Otherwise `sel_pulse <= 0`.
- **Load press.** On that same edge: `a <= s_sw[1:0]`, `b <= s_sw[3:2]` and `load_pulse <= 1`. Otherwise `load_pulse <= 0`.
- **Simultaneous events.** Select and load presses on the same edge are both applied; they are fully independent.
- **Held button.** A button held indefinitely produces exactly one event. The next event requires the debounced release, then a new debounced press.
- **Reset.** `rst` asserted at any time, including mid-count, immediately clears everything:
  - `a = 2'b00`, `b = 2'b00`, `sel = 0`, `sel_pulse = 0`, `load_pulse = 0`.
  - All synchronizer flops, `db` levels and counters are cleared to 0.
  - A button already held when `rst` deasserts is seen as a new press and yields one event after the full debounce latency.

## Timing
- **Latency.** A clean raw press that is stable before sampling edge 1 yields `db`, `sel` and `sel_pulse` updating at rising edge `DB_CYCLES+2`:
  - 2 edges of synchronization, then the debounce count.
  - At `DB_CYCLES=4`, this is edge 6.
- **Load latency.** Same as above. `a`/`b` capture the synchronized switches as seen at that edge; switches must be stable for at least 2 cycles before it.
- **Release.** `db` returns to 0 `DB_CYCLES+2` edges after a clean release. No output changes.
- **Strobes.** `sel_pulse` and `load_pulse` are exactly 1 cycle wide. The minimum spacing between two pulses of the same button is 2·`DB_CYCLES` cycles.
- **Stability.** All outputs are flops and change only on `clk` edges or asynchronously on `rst`.

## Test plan
All scenarios use `DB_CYCLES=4`, `CNT_W=3`.
- **Reset values.** Assert `rst` → `a=0`, `b=0`, `sel=0`, both pulses 0. Release `rst` with all inputs low → no change for 20 cycles.
- **Clean select press.** `btn_sel` goes high before edge 1 and is held 20 cycles → `sel` 0→1 and `sel_pulse=1` at edge 6 only. Release, then press again → `sel` 1→0. No toggle on release.
- **Bounce rejection.** `btn_sel` toggles high 3 cycles / low 1 cycle, repeated 5 times → `sel` unchanged. It then stays high → exactly one toggle, 6 edges after the final rise.
- **Load.** `sw=4'b1001` held, then press `btn_load` → at the event edge `a=2'b01`, `b=2'b10`, `load_pulse` 1 cycle. Change `sw` to `4'b0110` without pressing → `a`, `b` unchanged.
- **Simultaneous.** Press `btn_sel` and `btn_load` on the same cycle with `sw=4'b1100` → `sel` toggles, `a=2'b00`, `b=2'b11`, and both pulses are high in the same cycle.
- **Reset mid-count.** Press `btn_sel` and assert `rst` at edge 4 while holding the button → `sel` stays 0 during reset. After `rst` deasserts, one toggle occurs 6 edges later.
